// File: rtl/soc_irq_ctrl.sv
// APB-controlled interrupt controller: per-source sync, polarity, edge/level capture,
// enable mask, pending latch and highest-index-wins claim register.
module soc_irq_ctrl #(
    parameter int NUM_SRC        = 11,
    parameter int SYNC_STAGES    = 2,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int BUS_DATA_WIDTH = 32,
    localparam int ID_W          = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq_src_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [BUS_DATA_WIDTH-1:0] pwdata_i,
    output logic [BUS_DATA_WIDTH-1:0] prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [NUM_SRC-1:0]        irq_vec_o,
    output logic                      irq_o,
    output logic [ID_W-1:0]           irq_id_o
);

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q, pending_q, enable_q, mode_q, polarity_q;
    logic [NUM_SRC-1:0] s, rise, w1c_clr, claim_clr, pending_d, enable_d, active;
    logic [NUM_SRC-1:0] wdata;
    logic [ID_W-1:0]    id_d;
    logic [2:0]         reg_idx;
    logic               access, wr_commit, rd_commit;
    logic               unused_bits;

    assign unused_bits = ^{paddr_i, pwdata_i};

    assign access    = psel_i & penable_i;
    assign wr_commit = access & pwrite_i;
    assign rd_commit = access & ~pwrite_i;
    assign reg_idx   = paddr_i[4:2];
    assign wdata     = pwdata_i[NUM_SRC-1:0];

    assign s    = sync_q[SYNC_STAGES-1] ^ polarity_q;
    assign rise = s & ~prev_q;

    // W1C only touches edge-mode bits; level bits simply follow the source.
    assign w1c_clr = (wr_commit && reg_idx == 3'd0) ? (wdata & mode_q) : '0;

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rd_commit && reg_idx == 3'd4 && irq_id_o == ID_W'(i + 1) && mode_q[i]) begin
                claim_clr[i] = 1'b1;
            end
        end
    end

    // A new edge in the clearing cycle takes precedence over the clear.
    assign pending_d = (mode_q & ((pending_q & ~(w1c_clr | claim_clr)) | rise)) | (~mode_q & s);
    assign enable_d  = (wr_commit && reg_idx == 3'd1) ? wdata : enable_q;
    assign active    = pending_d & enable_d;

    always_comb begin
        id_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active[i]) id_d = ID_W'(i + 1);
        end
    end

    always_comb begin
        prdata_o  = '0;
        pslverr_o = 1'b0;
        if (access) begin
            case (reg_idx)
                3'd0:    prdata_o = BUS_DATA_WIDTH'(pending_q);
                3'd1:    prdata_o = BUS_DATA_WIDTH'(enable_q);
                3'd2:    prdata_o = BUS_DATA_WIDTH'(mode_q);
                3'd3:    prdata_o = BUS_DATA_WIDTH'(polarity_q);
                3'd4:    prdata_o = BUS_DATA_WIDTH'(irq_id_o);
                3'd5:    prdata_o = BUS_DATA_WIDTH'(s);
                default: pslverr_o = 1'b1;
            endcase
        end
    end

    assign pready_o = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            polarity_q <= '0;
            irq_vec_o  <= '0;
            irq_o      <= 1'b0;
            irq_id_o   <= '0;
        end else begin
            sync_q[0] <= irq_src_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q    <= s;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            if (wr_commit && reg_idx == 3'd2) mode_q <= wdata;
            if (wr_commit && reg_idx == 3'd3) polarity_q <= wdata;
            irq_vec_o <= active;
            irq_o     <= |active;
            irq_id_o  <= id_d;
        end
    end

endmodule

// File: tb/tb_soc_irq_ctrl.sv
// Self-checking bench for soc_irq_ctrl: directed scenarios plus a random phase, all
// compared every cycle against a behavioural model of the register rules.
module tb_soc_irq_ctrl;

    localparam int N  = 11;
    localparam int SY = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_src;
    logic          psel, penable, pwrite;
    logic [11:0]   paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready, pslverr;
    logic [N-1:0]  irq_vec;
    logic          irq;
    logic [3:0]    irq_id;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [N-1:0] m_pend, m_en, m_mode, m_pol, m_prev, m_vec;
    logic [N-1:0] m_samp [SY];
    logic [3:0]   m_id;

    soc_irq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src_i (irq_src),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .irq_vec_o (irq_vec),
        .irq_o     (irq),
        .irq_id_o  (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] top_id(input logic [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) if (v[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    task automatic m_reset();
        m_pend = '0; m_en = '0; m_mode = '0; m_pol = '0; m_prev = '0; m_vec = '0; m_id = '0;
        for (int i = 0; i < SY; i++) m_samp[i] = '0;
    endtask

    function automatic logic [N-1:0] m_raw();
        return m_samp[SY-1] ^ m_pol;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0: return 32'(m_pend);
            3'd1: return 32'(m_en);
            3'd2: return 32'(m_mode);
            3'd3: return 32'(m_pol);
            3'd4: return 32'(m_id);
            3'd5: return 32'(m_raw());
            default: return 32'd0;
        endcase
    endfunction

    // Apply the register rules for one clock edge, using the inputs held before it.
    task automatic m_edge();
        logic [N-1:0] sv, rise, clr, np;
        logic [2:0]   idx;
        logic         commit;
        sv     = m_raw();
        rise   = sv & ~m_prev;
        commit = psel & penable;
        idx    = paddr[4:2];
        clr    = '0;
        if (commit && pwrite && idx == 3'd0) clr = pwdata[N-1:0] & m_mode;
        if (commit && !pwrite && idx == 3'd4 && m_id != 0 && m_mode[int'(m_id) - 1])
            clr[int'(m_id) - 1] = 1'b1;
        np = (m_mode & ((m_pend & ~clr) | rise)) | (~m_mode & sv);
        if (commit && pwrite) begin
            case (idx)
                3'd1: m_en   = pwdata[N-1:0];
                3'd2: m_mode = pwdata[N-1:0];
                3'd3: m_pol  = pwdata[N-1:0];
                default: ;
            endcase
        end
        m_prev = sv;
        for (int i = SY - 1; i > 0; i--) m_samp[i] = m_samp[i-1];
        m_samp[0] = irq_src;
        m_pend = np;
        m_vec  = m_pend & m_en;
        m_id   = top_id(m_vec);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chk("irq_vec", 32'(irq_vec), 32'(m_vec));
        chk("irq", 32'(irq), 32'(|m_vec));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("pready", 32'(pready), 32'd1);
        if (!(psel && penable)) chk("prdata_idle", prdata, 32'd0);
    endtask

    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        logic [31:0] exp_rd;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        step();
        penable = 1'b1;
        #1;
        exp_rd = m_read(addr[4:2]);
        chk("pslverr", 32'(pslverr), 32'(addr[4:2] > 3'd5));
        if (!wr) chk("prdata", prdata, exp_rd);
        rd = prdata;
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1'b1; irq_src = '0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        m_reset();
        #12;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset values of every register, plus an undecoded offset
        for (int i = 0; i < 6; i++) begin
            apb(1'b0, 12'(i * 4), 32'd0, rd);
            chk("reset_reg", rd, 32'd0);
        end
        apb(1'b0, 12'h018, 32'd0, rd);

        // Edge pulse on src 3, then claim it
        apb(1'b1, 12'h008, 32'hFFFF_FFFF, rd);
        apb(1'b1, 12'h004, 32'h0000_07FF, rd);
        irq_src[3] = 1'b1; step();
        irq_src[3] = 1'b0; step();
        chk("src3_latency_early", 32'(irq), 32'd0);
        step();
        chk("src3_irq", 32'(irq), 32'd1);
        chk("src3_id", 32'(irq_id), 32'd4);
        apb(1'b0, 12'h010, 32'd0, rd);
        chk("claim_src3", rd, 32'd4);
        apb(1'b0, 12'h000, 32'd0, rd);
        chk("pending_after_claim", rd, 32'd0);
        chk("irq_after_claim", 32'(irq), 32'd0);

        // Two simultaneous edges: claimed highest first
        irq_src = 11'h204; step();
        irq_src = '0; step(); step();
        apb(1'b0, 12'h010, 32'd0, rd); chk("claim_first", rd, 32'd10);
        apb(1'b0, 12'h010, 32'd0, rd); chk("claim_second", rd, 32'd3);
        apb(1'b0, 12'h010, 32'd0, rd); chk("claim_empty", rd, 32'd0);

        // Level mode, active-low src 5
        apb(1'b1, 12'h008, 32'd0, rd);
        apb(1'b1, 12'h00C, 32'h20, rd);
        step(); step(); step();
        chk("lvl_id", 32'(irq_id), 32'd6);
        apb(1'b1, 12'h000, 32'h20, rd);
        apb(1'b0, 12'h000, 32'd0, rd);
        chk("lvl_w1c_ignored", rd, 32'h20);
        irq_src[5] = 1'b1; step(); step();
        chk("lvl_still_high", 32'(irq), 32'd1);
        step();
        chk("lvl_dropped", 32'(irq), 32'd0);
        apb(1'b1, 12'h00C, 32'd0, rd);
        irq_src = '0;
        step(); step(); step();

        // Edge on src 0 coincident with W1C: set wins
        apb(1'b1, 12'h008, 32'h7FF, rd);
        irq_src[0] = 1'b1; step();
        irq_src[0] = 1'b0; step(); step();
        apb(1'b1, 12'h000, 32'h1, rd);
        apb(1'b0, 12'h000, 32'd0, rd);
        chk("w1c_alone", rd, 32'd0);
        irq_src[0] = 1'b1; step();
        irq_src[0] = 1'b0; step(); step();
        irq_src[0] = 1'b1; step();
        irq_src[0] = 1'b0;
        apb(1'b1, 12'h000, 32'h1, rd);
        apb(1'b0, 12'h000, 32'd0, rd);
        chk("set_wins", rd & 32'h1, 32'h1);

        // Disabled sources still latch; enabling exposes them at once
        apb(1'b1, 12'h004, 32'd0, rd);
        irq_src[7] = 1'b1; step();
        irq_src[7] = 1'b0; step(); step();
        chk("disabled_irq", 32'(irq), 32'd0);
        apb(1'b0, 12'h000, 32'd0, rd);
        chk("disabled_pending", rd & 32'h80, 32'h80);
        apb(1'b1, 12'h004, 32'h80, rd);
        chk("enabled_id", 32'(irq_id), 32'd8);

        // Random phase
        apb(1'b1, 12'h004, 32'h7FF, rd);
        for (int it = 0; it < 500; it++) begin
            irq_src = irq_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
            if ($urandom_range(0, 9) < 4) begin
                step();
            end else begin
                apb(1'($urandom), 12'($urandom_range(0, 7) * 4), $urandom, rd);
            end
        end

        // Asynchronous reset during an ENABLE write with pending bits set
        irq_src = '0;
        apb(1'b1, 12'h008, 32'h7FF, rd);
        apb(1'b1, 12'h004, 32'h7FF, rd);
        step(); step(); step();
        irq_src = 11'h441; step();
        irq_src = '0; step(); step();
        chk("pre_reset_irq", 32'(irq), 32'd1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h7FF;
        step();
        penable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_vec", 32'(irq_vec), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_id", 32'(irq_id), 32'd0);
        chk("mid_rst_pready", 32'(pready), 32'd1);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst = 1'b0;
        step();
        apb(1'b0, 12'h004, 32'd0, rd);
        chk("enable_after_rst", rd, 32'd0);
        apb(1'b0, 12'h000, 32'd0, rd);
        chk("pending_after_rst", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_irq_ctrl.md
# soc_irq_ctrl

Parametrised interrupt controller between SoC peripherals and the core's `irq_sources` input. It replaces the fixed 11-bit, hard-priority interrupt vector wiring with a block that provides:
- per-source input synchronisation, polarity, edge/level mode, enable mask and pending latch;
- an APB slave for software control;
- a claim register that returns the highest-priority pending ID.

It hangs off the AXI2APB bridge as one APB device.

## Interface
Parameters:
- `NUM_SRC`, 11: number of interrupt sources, 1..32. Index order is GPIO1=10 … Timer=0 for the default SoC.
- `SYNC_STAGES`, 2: synchroniser flops per source, ≥1.
- `APB_ADDR_WIDTH`, 12: PADDR width; only bits [4:2] are decoded.
- `BUS_DATA_WIDTH`, 32: APB data width.
- `ID_W`, `$clog2(NUM_SRC+1)`: width of the interrupt ID (localparam).

Ports:
- `clk` in 1: single clock (the APB clock).
- `rst` in 1: asynchronous, active-high reset.
- `irq_src_i` in NUM_SRC: raw, asynchronous peripheral interrupt lines.
- `psel_i`, `penable_i`, `pwrite_i` in 1 each: APB control.
- `paddr_i` in APB_ADDR_WIDTH: APB address.
- `pwdata_i` in BUS_DATA_WIDTH: APB write data.
- `prdata_o` out BUS_DATA_WIDTH: APB read data.
- `pready_o` out 1: always 1 (zero wait states).
- `pslverr_o` out 1: error on an undecoded offset.
- `irq_vec_o` out NUM_SRC: registered `pending & enable`, to the core.
- `irq_o` out 1: registered OR of `irq_vec_o`.
- `irq_id_o` out ID_W: registered (highest active index)+1; 0 when none.

## Operation
Register map (word offsets):
- 0x00 PENDING: R/W1C. W1C acts on edge-mode bits only.
- 0x04 ENABLE: RW, reset 0.
- 0x08 MODE: RW, 1 = rising-edge, 0 = level, reset 0.
- 0x0C POLARITY: RW, 1 = active-low, reset 0.
- 0x10 CLAIM: RO. Read returns the current `irq_id_o` value. If that ID is nonzero and its source is edge mode, the read clears the corresponding pending bit.
- 0x14 RAW: RO, synchronised value after polarity inversion.
- Offsets above 0x14: `pslverr_o` = 1 in the access phase, `prdata_o` = 0, and writes are ignored.
- Bits ≥ NUM_SRC read 0 and ignore writes.

Per-source datapath:
- `sync` chain of SYNC_STAGES flops.
- `s = sync_last ^ polarity`.
- `prev <= s` every cycle, in both modes, so switching mode never creates a spurious edge.
- Edge mode: `pending` is set on `s & ~prev`. It is cleared by W1C or by a claim. If set and clear occur in the same cycle, **set wins**.
- Level mode: `pending <= s` every cycle.
- Priority: the highest index wins; ID = index+1.
- `irq_vec_o`, `irq_o` and `irq_id_o` are all registered from next-state `pending & enable`, so they always agree with the PENDING register.
- Disabled sources still latch pending.

APB:
- A transfer is committed on the edge where `psel_i & penable_i` is high.
- `prdata_o` is combinational during the access phase and 0 otherwise.
- A claim side effect occurs only on a committed read of 0x10 (`pwrite_i` = 0).

## Timing
- Reset, asynchronous: every flop clears at once, including the synchronisers, `prev`, all registers and all outputs. `pready_o` stays 1.
- A pulse asserted or deasserted during reset is lost.
- A source edge sampled at clock edge k sets `pending` at edge k+SYNC_STAGES. The same edge updates `irq_vec_o`, `irq_o` and `irq_id_o`, since they are registered from next-state pending.
- Software clear (W1C or claim) committed at edge c: pending and the outputs drop at edge c, unless a new edge sets the bit in the same cycle.
- A level source deasserted at edge k drops its outputs at edge k+SYNC_STAGES.
- A write to ENABLE committed at edge c updates the outputs at edge c.
- Back-to-back APB accesses are supported, at one transfer per 2 cycles.
- Input pulses shorter than one clock period may be missed. They are not guaranteed to be captured.

## Test plan
- Reset, then read every register. Expected: all 0, `irq_o` = 0, `irq_id_o` = 0; offset 0x18 gives `pslverr_o` = 1.
- MODE=0x7FF, ENABLE=0x7FF, one-cycle pulse on src 3. Expected: `irq_o` = 1 and `irq_id_o` = 4 exactly 2 cycles after sampling; a CLAIM read returns 4; PENDING then reads 0 and `irq_o` drops.
- Pulse src 2 and src 9 together. Expected: first CLAIM returns 10, second returns 3, third returns 0.
- Level mode, POLARITY bit 5 = 1, hold src 5 low. Expected: `irq_id_o` = 6. A W1C to bit 5 has no effect; driving src 5 high drops `irq_o` 2 cycles later.
- Edge src 0 with an edge detected in the same cycle as a committed W1C of bit 0. Expected: PENDING bit 0 remains 1.
- Assert `rst` mid-way through an APB write to ENABLE with pending bits set. Expected: all outputs 0 immediately; ENABLE reads 0 after reset.
